// File: rtl/detector_scan_sequencer.sv
// Scan sequencer for the detector bank: settles, averages and thresholds each
// channel in turn, then hands one result word per channel to the host logger.
module detector_scan_sequencer #(
    parameter int N_CH        = 6,
    parameter int SAMPLE_W    = 12,
    parameter int ACC_LOG2    = 4,
    parameter int SETTLE_CYC  = 4,
    parameter int TIMEOUT_CYC = 255,
    localparam int CH_W       = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                abort,
    input  logic [SAMPLE_W-1:0] threshold,
    output logic [CH_W-1:0]     ch_sel,
    output logic                sample_req,
    input  logic                sample_valid,
    input  logic [SAMPLE_W-1:0] sample_data,
    output logic                res_valid,
    input  logic                res_ready,
    output logic [CH_W-1:0]     res_ch,
    output logic [SAMPLE_W-1:0] res_avg,
    output logic                res_pos,
    output logic                res_err,
    output logic                busy,
    output logic                done
);

    localparam int ACC_W  = SAMPLE_W + ACC_LOG2;
    localparam int SCNT_W = (ACC_LOG2 > 0) ? ACC_LOG2 : 1;
    localparam int SET_W  = $clog2(SETTLE_CYC + 1);
    localparam int TMO_W  = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETTLE = 3'd1,
        ST_SAMPLE = 3'd2,
        ST_EMIT   = 3'd3,
        ST_FINISH = 3'd4
    } state_t;

    state_t              state_r, state_s;
    logic [CH_W-1:0]     ch_r, ch_s;
    logic [ACC_W-1:0]    acc_r, acc_s;
    logic [SCNT_W-1:0]   samp_cnt_r, samp_cnt_s;
    logic [SET_W-1:0]    settle_cnt_r, settle_cnt_s;
    logic [TMO_W-1:0]    tmo_cnt_r, tmo_cnt_s;
    logic [SAMPLE_W-1:0] thr_r, thr_s;
    logic [SAMPLE_W-1:0] res_avg_r, res_avg_s;
    logic                res_pos_r, res_pos_s;
    logic                res_err_r, res_err_s;
    logic                sample_req_r, res_valid_r, busy_r, done_r;
    logic [ACC_W-1:0]    acc_sum_s;
    logic [SAMPLE_W-1:0] avg_s;

    // Running sum including the sample arriving this cycle; the average is the truncated top bits.
    always_comb begin
        acc_sum_s = acc_r + ACC_W'(sample_data);
        avg_s     = acc_sum_s[ACC_W-1:ACC_LOG2];
    end

    // Next-state and datapath update; abort overrides everything outside IDLE.
    always_comb begin
        state_s      = state_r;
        ch_s         = ch_r;
        acc_s        = acc_r;
        samp_cnt_s   = samp_cnt_r;
        settle_cnt_s = settle_cnt_r;
        tmo_cnt_s    = tmo_cnt_r;
        thr_s        = thr_r;
        res_avg_s    = res_avg_r;
        res_pos_s    = res_pos_r;
        res_err_s    = res_err_r;
        if (abort && (state_r != ST_IDLE)) begin
            state_s      = ST_IDLE;
            ch_s         = '0;
            acc_s        = '0;
            samp_cnt_s   = '0;
            settle_cnt_s = '0;
            tmo_cnt_s    = '0;
            res_avg_s    = '0;
            res_pos_s    = 1'b0;
            res_err_s    = 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start && !abort) begin
                        thr_s        = threshold;
                        ch_s         = '0;
                        acc_s        = '0;
                        samp_cnt_s   = '0;
                        settle_cnt_s = '0;
                        tmo_cnt_s    = '0;
                        state_s      = ST_SETTLE;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end
                ST_SETTLE: begin
                    if (settle_cnt_r == SET_W'(SETTLE_CYC - 1)) begin
                        settle_cnt_s = '0;
                        state_s      = ST_SAMPLE;
                    end else begin
                        settle_cnt_s = settle_cnt_r + SET_W'(1);
                    end
                end
                ST_SAMPLE: begin
                    if (sample_valid) begin
                        acc_s     = acc_sum_s;
                        tmo_cnt_s = '0;
                        if (samp_cnt_r == SCNT_W'((1 << ACC_LOG2) - 1)) begin
                            res_avg_s = avg_s;
                            res_pos_s = (avg_s >= thr_r);
                            res_err_s = 1'b0;
                            state_s   = ST_EMIT;
                        end else begin
                            samp_cnt_s = samp_cnt_r + SCNT_W'(1);
                        end
                    end else if (tmo_cnt_r == TMO_W'(TIMEOUT_CYC - 1)) begin
                        // Converter went silent: report the channel as failed rather than stall the scan.
                        res_avg_s = '0;
                        res_pos_s = 1'b0;
                        res_err_s = 1'b1;
                        state_s   = ST_EMIT;
                    end else begin
                        tmo_cnt_s = tmo_cnt_r + TMO_W'(1);
                    end
                end
                ST_EMIT: begin
                    if (res_ready) begin
                        if (ch_r < CH_W'(N_CH - 1)) begin
                            ch_s         = ch_r + CH_W'(1);
                            acc_s        = '0;
                            samp_cnt_s   = '0;
                            settle_cnt_s = '0;
                            tmo_cnt_s    = '0;
                            state_s      = ST_SETTLE;
                        end else begin
                            state_s = ST_FINISH;
                        end
                    end else begin
                        state_s = ST_EMIT;
                    end
                end
                ST_FINISH: begin
                    state_s = ST_IDLE;
                end
                default: begin
                    state_s = ST_IDLE;
                end
            endcase
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Channel, accumulator, counters, latched threshold and result word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ch_r         <= '0;
            acc_r        <= '0;
            samp_cnt_r   <= '0;
            settle_cnt_r <= '0;
            tmo_cnt_r    <= '0;
            thr_r        <= '0;
            res_avg_r    <= '0;
            res_pos_r    <= 1'b0;
            res_err_r    <= 1'b0;
        end else begin
            ch_r         <= ch_s;
            acc_r        <= acc_s;
            samp_cnt_r   <= samp_cnt_s;
            settle_cnt_r <= settle_cnt_s;
            tmo_cnt_r    <= tmo_cnt_s;
            thr_r        <= thr_s;
            res_avg_r    <= res_avg_s;
            res_pos_r    <= res_pos_s;
            res_err_r    <= res_err_s;
        end
    end

    // Control outputs registered from the next state so they align with the state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sample_req_r <= 1'b0;
            res_valid_r  <= 1'b0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
        end else begin
            sample_req_r <= (state_s == ST_SAMPLE);
            res_valid_r  <= (state_s == ST_EMIT);
            busy_r       <= (state_s != ST_IDLE);
            done_r       <= (state_s == ST_FINISH);
        end
    end

    assign ch_sel     = ch_r;
    assign sample_req = sample_req_r;
    assign res_valid  = res_valid_r;
    assign res_ch     = ch_r;
    assign res_avg    = res_avg_r;
    assign res_pos    = res_pos_r;
    assign res_err    = res_err_r;
    assign busy       = busy_r;
    assign done       = done_r;

endmodule
